// File: rtl/lite_regbus_pkg.sv
// Shared constants and types for the NASTI-Lite to register-bus slave endpoint.
package lite_regbus_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    BRESP  = 2'd2,
    RRESP  = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

endpackage

// File: rtl/lite_regbus_slave.sv
// NASTI-Lite slave that serialises one read or write at a time onto a req/ack register bus.
// Optional reg_ack timeout with DECERR response when LITE_REGBUS_TIMEOUT_EN is defined.
module lite_regbus_slave
  import lite_regbus_pkg::*;
#(
  parameter int ID_WIDTH       = 1,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ID_WIDTH-1:0]     lite_aw_id,
  input  logic [ADDR_WIDTH-1:0]   lite_aw_addr,
  input  logic [2:0]              lite_aw_prot,
  input  logic [3:0]              lite_aw_qos,
  input  logic [3:0]              lite_aw_region,
  input  logic [USER_WIDTH-1:0]   lite_aw_user,
  input  logic                    lite_aw_valid,
  output logic                    lite_aw_ready,
  input  logic [DATA_WIDTH-1:0]   lite_w_data,
  input  logic [DATA_WIDTH/8-1:0] lite_w_strb,
  input  logic [USER_WIDTH-1:0]   lite_w_user,
  input  logic                    lite_w_valid,
  output logic                    lite_w_ready,
  output logic [ID_WIDTH-1:0]     lite_b_id,
  output logic [1:0]              lite_b_resp,
  output logic [USER_WIDTH-1:0]   lite_b_user,
  output logic                    lite_b_valid,
  input  logic                    lite_b_ready,
  input  logic [ID_WIDTH-1:0]     lite_ar_id,
  input  logic [ADDR_WIDTH-1:0]   lite_ar_addr,
  input  logic [2:0]              lite_ar_prot,
  input  logic [3:0]              lite_ar_qos,
  input  logic [3:0]              lite_ar_region,
  input  logic [USER_WIDTH-1:0]   lite_ar_user,
  input  logic                    lite_ar_valid,
  output logic                    lite_ar_ready,
  output logic [ID_WIDTH-1:0]     lite_r_id,
  output logic [DATA_WIDTH-1:0]   lite_r_data,
  output logic [1:0]              lite_r_resp,
  output logic [USER_WIDTH-1:0]   lite_r_user,
  output logic                    lite_r_valid,
  input  logic                    lite_r_ready,
  output logic                    reg_req,
  output logic                    reg_we,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_ack,
  input  logic                    reg_err
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  grant_e                  last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    we_q, we_d;
  logic [1:0]              resp_q, resp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic wr_eligible, rd_eligible, grant_wr, grant_rd;
  logic unused_ok;

`ifdef LITE_REGBUS_TIMEOUT_EN
  localparam int                CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign unused_ok = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_w_user,
                       lite_ar_prot, lite_ar_qos, lite_ar_region};
`else
  localparam logic [31:0] TIMEOUT_VEC = 32'(TIMEOUT_CYCLES);

  assign unused_ok = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_w_user,
                       lite_ar_prot, lite_ar_qos, lite_ar_region, TIMEOUT_VEC};
`endif

  // A write needs both address and data in the same cycle; round-robin only on a tie.
  assign wr_eligible = lite_aw_valid && lite_w_valid;
  assign rd_eligible = lite_ar_valid;
  assign grant_wr    = rstn && (state_q == IDLE) && wr_eligible &&
                       (!rd_eligible || (last_grant_q == GRANT_READ));
  assign grant_rd    = rstn && (state_q == IDLE) && rd_eligible && !grant_wr;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    user_d        = user_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    we_d          = we_q;
    resp_d        = resp_q;
    rdata_d       = rdata_q;
    lite_aw_ready = 1'b0;
    lite_w_ready  = 1'b0;
    lite_ar_ready = 1'b0;
`ifdef LITE_REGBUS_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          lite_aw_ready = 1'b1;
          lite_w_ready  = 1'b1;
          id_d          = lite_aw_id;
          user_d        = lite_aw_user;
          addr_d        = lite_aw_addr;
          wdata_d       = lite_w_data;
          wstrb_d       = lite_w_strb;
          we_d          = 1'b1;
          last_grant_d  = GRANT_WRITE;
          state_d       = ACCESS;
        end else if (grant_rd) begin
          lite_ar_ready = 1'b1;
          id_d          = lite_ar_id;
          user_d        = lite_ar_user;
          addr_d        = lite_ar_addr;
          we_d          = 1'b0;
          last_grant_d  = GRANT_READ;
          state_d       = ACCESS;
        end
`ifdef LITE_REGBUS_TIMEOUT_EN
        cnt_d = '0;
`endif
      end

      ACCESS: begin
        if (reg_ack) begin
          resp_d  = reg_err ? RESP_SLVERR : RESP_OKAY;
          if (!we_q) begin
            rdata_d = reg_err ? '0 : reg_rdata;
          end
          state_d = we_q ? BRESP : RRESP;
`ifdef LITE_REGBUS_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          resp_d  = RESP_DECERR;
          rdata_d = '0;
          state_d = we_q ? BRESP : RRESP;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
`endif
        end
      end

      BRESP: if (lite_b_ready) state_d = IDLE;
      RRESP: if (lite_r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_READ;
      id_q         <= '0;
      user_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      we_q         <= 1'b0;
      resp_q       <= RESP_OKAY;
      rdata_q      <= '0;
`ifdef LITE_REGBUS_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      user_q       <= user_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      we_q         <= we_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
`ifdef LITE_REGBUS_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign reg_req      = (state_q == ACCESS);
  assign reg_we       = reg_req && we_q;
  assign reg_addr     = addr_q;
  assign reg_wdata    = wdata_q;
  assign reg_wstrb    = wstrb_q;

  assign lite_b_valid = (state_q == BRESP);
  assign lite_b_id    = id_q;
  assign lite_b_user  = user_q;
  assign lite_b_resp  = resp_q;

  assign lite_r_valid = (state_q == RRESP);
  assign lite_r_id    = id_q;
  assign lite_r_user  = user_q;
  assign lite_r_resp  = resp_q;
  assign lite_r_data  = rdata_q;

endmodule

// File: tb/tb_lite_regbus_slave.sv
// Directed bench for lite_regbus_slave: transaction-level model, per-cycle compare, literal pins.
module tb_lite_regbus_slave;

  localparam int IW = 1, AW = 8, DW = 32, UW = 1, SW = 4, TMO = 4;

  logic          clk, rstn;
  logic [IW-1:0] aw_id, ar_id, b_id, r_id;
  logic [AW-1:0] aw_addr, ar_addr, reg_addr;
  logic [UW-1:0] aw_user, w_user, ar_user, b_user, r_user;
  logic          aw_valid, aw_ready, w_valid, w_ready, ar_valid, ar_ready;
  logic [DW-1:0] w_data, r_data, reg_wdata, reg_rdata;
  logic [SW-1:0] w_strb, reg_wstrb;
  logic [1:0]    b_resp, r_resp;
  logic          b_valid, b_ready, r_valid, r_ready;
  logic          reg_req, reg_we, reg_ack, reg_err;
  logic [2:0]    prot;
  logic [3:0]    qos, region;

  lite_regbus_slave #(
    .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .lite_aw_id(aw_id), .lite_aw_addr(aw_addr), .lite_aw_prot(prot), .lite_aw_qos(qos),
    .lite_aw_region(region), .lite_aw_user(aw_user), .lite_aw_valid(aw_valid), .lite_aw_ready(aw_ready),
    .lite_w_data(w_data), .lite_w_strb(w_strb), .lite_w_user(w_user), .lite_w_valid(w_valid),
    .lite_w_ready(w_ready),
    .lite_b_id(b_id), .lite_b_resp(b_resp), .lite_b_user(b_user), .lite_b_valid(b_valid),
    .lite_b_ready(b_ready),
    .lite_ar_id(ar_id), .lite_ar_addr(ar_addr), .lite_ar_prot(prot), .lite_ar_qos(qos),
    .lite_ar_region(region), .lite_ar_user(ar_user), .lite_ar_valid(ar_valid), .lite_ar_ready(ar_ready),
    .lite_r_id(r_id), .lite_r_data(r_data), .lite_r_resp(r_resp), .lite_r_user(r_user),
    .lite_r_valid(r_valid), .lite_r_ready(r_ready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit            wr;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    bit            err;
    bit            tmo;
    logic [DW-1:0] rdata;
  } txn_t;

  function automatic txn_t mk(bit wr, logic [IW-1:0] id, logic [AW-1:0] addr, logic [DW-1:0] d,
                              logic [SW-1:0] strb, logic [UW-1:0] user, bit err, bit tmo);
    txn_t t;
    t.wr = wr; t.id = id; t.addr = addr; t.strb = strb; t.user = user; t.err = err; t.tmo = tmo;
    t.wdata = wr ? d : '0;
    t.rdata = wr ? '0 : d;
    return t;
  endfunction

  // Model: response code and read data follow directly from how the peripheral answered.
  function automatic logic [1:0] exp_resp(txn_t t);
    return t.tmo ? 2'b11 : (t.err ? 2'b10 : 2'b00);
  endfunction
  function automatic logic [DW-1:0] exp_rdata(txn_t t);
    return (t.tmo || t.err) ? '0 : t.rdata;
  endfunction

  bit   model_last_wr = 1'b0;
  function automatic bit model_grant_write(bit w_elig, bit r_elig);
    return w_elig && (!r_elig || !model_last_wr);
  endfunction

  txn_t          cur;
  bit            cur_valid = 1'b0;
  logic          last_aw_ready;
  logic [1:0]    obs_resp;
  logic [DW-1:0] obs_rdata;
  logic [IW-1:0] obs_id;
  logic [AW-1:0] obs_addr;

  always @(negedge clk) begin
    if (cur_valid && rstn) begin
      if (reg_req) begin
        check("reg_we", reg_we, cur.wr);
        check("reg_addr", reg_addr, cur.addr);
        if (cur.wr) begin
          check("reg_wdata", reg_wdata, cur.wdata);
          check("reg_wstrb", reg_wstrb, cur.strb);
        end
      end
      if (b_valid || r_valid) begin
        check("b_valid_kind", b_valid, cur.wr);
        check("r_valid_kind", r_valid, !cur.wr);
        if (cur.wr) begin
          check("b_id", b_id, cur.id);
          check("b_user", b_user, cur.user);
          check("b_resp", b_resp, exp_resp(cur));
        end else begin
          check("r_id", r_id, cur.id);
          check("r_user", r_user, cur.user);
          check("r_resp", r_resp, exp_resp(cur));
          check("r_data", r_data, exp_rdata(cur));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valids();
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
  endtask

  // Runs one transaction starting at posedge+1; lat = ACCESS cycles before ack, bp = cycles of ready low.
  task automatic run(input bit wv, input bit wdv, input bit rv, input txn_t wt, input txn_t rt,
                     input int lat, input int bp);
    bit gw;
    int n;
    int cnt;
    aw_valid = wv;  aw_id = wt.id; aw_addr = wt.addr; aw_user = wt.user;
    w_valid  = wdv; w_data = wt.wdata; w_strb = wt.strb;
    ar_valid = rv;  ar_id = rt.id; ar_addr = rt.addr; ar_user = rt.user;
    gw = model_grant_write(wv && wdv, rv);
    cur = gw ? wt : rt;
    cur_valid = 1'b1;
    model_last_wr = gw;
    @(negedge clk);
    check("aw_ready_grant", aw_ready, gw);
    check("w_ready_grant", w_ready, gw);
    check("ar_ready_grant", ar_ready, !gw);
    last_aw_ready = aw_ready;
    step();
    @(negedge clk);
    check("no_ready_in_access", {aw_ready, w_ready, ar_ready}, 3'b000);
    check("req_after_grant", reg_req, 1'b1);
    obs_addr = reg_addr;
    drop_valids();
    if (!cur.tmo) begin
      repeat (lat) begin
        @(posedge clk);
        @(negedge clk);
        check("req_held", reg_req, 1'b1);
      end
      reg_ack = 1'b1; reg_err = cur.err; reg_rdata = cur.rdata;
      step();
      reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
    end
    n = 0;
    cnt = 0;
    while (n < 20 && !(b_valid || r_valid)) begin
      if (reg_req) cnt++;
      n++;
      step();
      @(negedge clk);
    end
    check("resp_valid_seen", b_valid || r_valid, 1'b1);
    check("resp_latency", n, cur.tmo ? TMO : 0);
    if (cur.tmo) check("tmo_req_cycles", cnt, TMO);
    check("req_dropped", reg_req, 1'b0);
    obs_resp  = cur.wr ? b_resp : r_resp;
    obs_rdata = r_data;
    obs_id    = cur.wr ? b_id : r_id;
    repeat (bp) begin
      step();
      @(negedge clk);
      check("resp_held", cur.wr ? b_valid : r_valid, 1'b1);
    end
    step();
    if (cur.wr) b_ready = 1'b1; else r_ready = 1'b1;
    @(negedge clk);
    check("resp_valid_at_ready", cur.wr ? b_valid : r_valid, 1'b1);
    step();
    b_ready = 1'b0; r_ready = 1'b0;
    @(negedge clk);
    check("resp_done", b_valid || r_valid, 1'b0);
    step();
  endtask

  task automatic late_ack_ignored(input string name);
    reg_ack = 1'b1; reg_rdata = 32'hFFFF_FFFF;
    step();
    reg_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check(name, {reg_req, b_valid, r_valid}, 3'b000);
      step();
    end
  endtask

  txn_t wt, rt;
  bit [2:0] arb;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; drop_valids();
    aw_id = '0; aw_addr = '0; aw_user = '0; w_data = '0; w_strb = '0; w_user = '0;
    ar_id = '0; ar_addr = '0; ar_user = '0; b_ready = 1'b0; r_ready = 1'b0;
    reg_rdata = '0; reg_ack = 1'b0; reg_err = 1'b0; prot = '0; qos = '0; region = '0;
    repeat (3) step();
    @(negedge clk);
    check("rst_readies", {aw_ready, w_ready, ar_ready}, 3'b000);
    check("rst_valids", {b_valid, r_valid}, 2'b00);
    check("rst_req_we", {reg_req, reg_we}, 2'b00);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_resp", {b_resp, r_resp}, 4'b0000);
    check("rst_r_data", r_data, 0);
    step();
    rstn = 1'b1;
    step();

    wt = mk(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b0, wt, wt, 1, 2);
    check("lit_wr_addr", obs_addr, 8'h10);
    check("lit_wr_resp", obs_resp, 2'b00);
    check("lit_wr_id", obs_id, 1'b1);

    rt = mk(1'b0, 1'b0, 8'h20, 32'h12345678, 4'h0, 1'b0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, wt, rt, 0, 3);
    check("lit_rd_data", obs_rdata, 32'h12345678);
    check("lit_rd_resp", obs_resp, 2'b00);

    for (int i = 0; i < 3; i++) begin
      wt = mk(1'b1, 1'(i), 8'h40 + 8'(i), 32'hA000_0000 + 32'(i), 4'(i + 3), 1'(i), 1'b0, 1'b0);
      rt = mk(1'b0, 1'(i + 1), 8'h50 + 8'(i), 32'hC000_0000 + 32'(i), 4'h0, 1'(i + 1), 1'b0, 1'b0);
      run(1'b1, 1'b1, 1'b1, wt, rt, 0, 0);
      arb[2 - i] = last_aw_ready;
    end
    check("lit_arb_wrw", arb, 3'b101);

    wt = mk(1'b1, 1'b1, 8'h14, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b1, 1'b0);
    run(1'b1, 1'b1, 1'b0, wt, wt, 2, 1);
    check("lit_wr_slverr", obs_resp, 2'b10);

    rt = mk(1'b0, 1'b1, 8'h24, 32'hAAAA_5555, 4'h0, 1'b1, 1'b1, 1'b0);
    run(1'b0, 1'b0, 1'b1, wt, rt, 1, 0);
    check("lit_rd_slverr_data", obs_rdata, 0);
    check("lit_rd_slverr_resp", obs_resp, 2'b10);

    wt = mk(1'b1, 1'b0, 8'h30, 32'h1111_2222, 4'hF, 1'b0, 1'b0, 1'b0);
    rt = mk(1'b0, 1'b1, 8'h34, 32'h5A5A_A5A5, 4'h0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 1'b1, wt, rt, 0, 0);
    check("lit_aw_only_no_ready", last_aw_ready, 1'b0);
    check("lit_aw_only_rd_data", obs_rdata, 32'h5A5A_A5A5);

`ifdef LITE_REGBUS_TIMEOUT_EN
    rt = mk(1'b0, 1'b1, 8'h3C, 32'h7777_7777, 4'h0, 1'b1, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1'b1, wt, rt, 0, 0);
    check("lit_tmo_resp", obs_resp, 2'b11);
    check("lit_tmo_data", obs_rdata, 0);
    late_ack_ignored("tmo_late_ack");
`endif

    // Reset in the middle of a write's ACCESS phase.
    wt = mk(1'b1, 1'b0, 8'h60, 32'hCAFE_0001, 4'hF, 1'b0, 1'b0, 1'b0);
    aw_valid = 1'b1; w_valid = 1'b1; aw_id = wt.id; aw_addr = wt.addr; aw_user = wt.user;
    w_data = wt.wdata; w_strb = wt.strb;
    cur = wt; cur_valid = 1'b1; model_last_wr = 1'b1;
    @(negedge clk);
    check("mid_rst_grant", aw_ready, 1'b1);
    step();
    drop_valids();
    @(negedge clk);
    check("mid_rst_req_before", reg_req, 1'b1);
    rstn = 1'b0;
    step();
    cur_valid = 1'b0;
    model_last_wr = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", {reg_req, reg_we, b_valid, r_valid}, 4'b0000);
    check("mid_rst_addr", reg_addr, 0);
    rstn = 1'b1;
    step();
    late_ack_ignored("rst_late_ack");

    wt = mk(1'b1, 1'b1, 8'h70, 32'h0F0F_0F0F, 4'h5, 1'b1, 1'b0, 1'b0);
    rt = mk(1'b0, 1'b0, 8'h74, 32'h1234_0000, 4'h0, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b1, wt, rt, 1, 1);
    check("lit_post_rst_write_first", last_aw_ready, 1'b1);
    check("lit_post_rst_resp", obs_resp, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
